// File: rtl/ysyx_23060187_wbu_gen.sv
// Write-back unit: one-entry buffer, optional store with response, commit to RF/IFU.
// Optional forwarding port enabled by defining WBU_FWD_EN.
module ysyx_23060187_wbu_gen #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned NREG = 32,
   parameter int unsigned RW   = $clog2(NREG)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              exu_wbu_valid,
   output logic              wbu_exu_ready,
   input  logic              exu_rd_wen,
   input  logic [RW-1:0]     exu_rd,
   input  logic [XLEN-1:0]   exu_rd_wdata,
   input  logic              exu_mem_wen,
   input  logic [XLEN-1:0]   exu_mem_waddr,
   input  logic [XLEN-1:0]   exu_mem_wdata,
   input  logic [XLEN/8-1:0] exu_mem_wstrb,
   input  logic [XLEN-1:0]   exu_next_pc,
   output logic              rf_wen,
   output logic [RW-1:0]     rf_waddr,
   output logic [XLEN-1:0]   rf_wdata,
   output logic              mem_wvalid,
   input  logic              mem_wready,
   output logic [XLEN-1:0]   mem_waddr,
   output logic [XLEN-1:0]   mem_wdata,
   output logic [XLEN/8-1:0] mem_wstrb,
   input  logic              mem_bvalid,
   input  logic [1:0]        mem_bresp,
   output logic              mem_bready,
   output logic              wbu_ifu_valid,
   input  logic              ifu_wbu_ready,
   output logic [XLEN-1:0]   wbu_ifu_pc,
`ifdef WBU_FWD_EN
   output logic              fwd_valid,
   output logic [RW-1:0]     fwd_rd,
   output logic [XLEN-1:0]   fwd_data,
`endif
   output logic              wbu_err
);

   typedef enum logic [1:0] {
      IDLE,
      MEM_REQ,
      MEM_RESP,
      COMMIT
   } state_e;

   state_e              state_q, state_d;
   logic                rd_wen_q, rd_wen_d;
   logic [RW-1:0]       rd_q, rd_d;
   logic [XLEN-1:0]     rd_wdata_q, rd_wdata_d;
   logic [XLEN-1:0]     waddr_q, waddr_d;
   logic [XLEN-1:0]     wdata_q, wdata_d;
   logic [XLEN/8-1:0]   wstrb_q, wstrb_d;
   logic [XLEN-1:0]     pc_q, pc_d;
   logic                err_q, err_d;
   logic                rd_live;

   // x0 is hardwired to zero, so a write to it is never a real write
   assign rd_live = rd_wen_q && (rd_q != '0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         rd_wen_q   <= 1'b0;
         rd_q       <= '0;
         rd_wdata_q <= '0;
         waddr_q    <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         pc_q       <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         rd_wen_q   <= rd_wen_d;
         rd_q       <= rd_d;
         rd_wdata_q <= rd_wdata_d;
         waddr_q    <= waddr_d;
         wdata_q    <= wdata_d;
         wstrb_q    <= wstrb_d;
         pc_q       <= pc_d;
         err_q      <= err_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      rd_wen_d      = rd_wen_q;
      rd_d          = rd_q;
      rd_wdata_d    = rd_wdata_q;
      waddr_d       = waddr_q;
      wdata_d       = wdata_q;
      wstrb_d       = wstrb_q;
      pc_d          = pc_q;
      err_d         = err_q;
      wbu_exu_ready = 1'b0;
      mem_wvalid    = 1'b0;
      mem_bready    = 1'b0;
      wbu_ifu_valid = 1'b0;
      rf_wen        = 1'b0;
      unique case (state_q)
         IDLE: begin
            // ready is held low while reset is asserted
            wbu_exu_ready = rst;
            if (exu_wbu_valid) begin
               rd_wen_d   = exu_rd_wen;
               rd_d       = exu_rd;
               rd_wdata_d = exu_rd_wdata;
               waddr_d    = exu_mem_waddr;
               wdata_d    = exu_mem_wdata;
               wstrb_d    = exu_mem_wstrb;
               pc_d       = exu_next_pc;
               state_d    = exu_mem_wen ? MEM_REQ : COMMIT;
            end
         end
         MEM_REQ: begin
            mem_wvalid = 1'b1;
            if (mem_wready) begin
               state_d = MEM_RESP;
            end
         end
         MEM_RESP: begin
            mem_bready = 1'b1;
            if (mem_bvalid) begin
               if (mem_bresp != 2'b00) begin
                  err_d = 1'b1;
               end
               state_d = COMMIT;
            end
         end
         COMMIT: begin
            wbu_ifu_valid = 1'b1;
            if (ifu_wbu_ready) begin
               rf_wen  = rd_live;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign rf_waddr   = rd_q;
   assign rf_wdata   = rd_wdata_q;
   assign mem_waddr  = waddr_q;
   assign mem_wdata  = wdata_q;
   assign mem_wstrb  = wstrb_q;
   assign wbu_ifu_pc = pc_q;
   assign wbu_err    = err_q;

`ifdef WBU_FWD_EN
   assign fwd_valid = (state_q != IDLE) && rd_live;
   assign fwd_rd    = rd_q;
   assign fwd_data  = rd_wdata_q;
`endif

endmodule

// File: tb/tb_ysyx_23060187_wbu_gen.sv
// Directed bench for the write-back unit.
// Define WBU_FWD_EN to also exercise the forwarding port.
module tb_ysyx_23060187_wbu_gen;

   logic        clk;
   logic        rst;
   logic        exu_wbu_valid;
   logic        wbu_exu_ready;
   logic        exu_rd_wen;
   logic [4:0]  exu_rd;
   logic [31:0] exu_rd_wdata;
   logic        exu_mem_wen;
   logic [31:0] exu_mem_waddr;
   logic [31:0] exu_mem_wdata;
   logic [3:0]  exu_mem_wstrb;
   logic [31:0] exu_next_pc;
   logic        rf_wen;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        mem_wvalid;
   logic        mem_wready;
   logic [31:0] mem_waddr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_bvalid;
   logic [1:0]  mem_bresp;
   logic        mem_bready;
   logic        wbu_ifu_valid;
   logic        ifu_wbu_ready;
   logic [31:0] wbu_ifu_pc;
   logic        wbu_err;
`ifdef WBU_FWD_EN
   logic        fwd_valid;
   logic [4:0]  fwd_rd;
   logic [31:0] fwd_data;
`endif

   int checks;
   int errors;

   ysyx_23060187_wbu_gen #(
      .XLEN(32),
      .NREG(32)
   ) dut (
      .clk(clk),
      .rst(rst),
      .exu_wbu_valid(exu_wbu_valid),
      .wbu_exu_ready(wbu_exu_ready),
      .exu_rd_wen(exu_rd_wen),
      .exu_rd(exu_rd),
      .exu_rd_wdata(exu_rd_wdata),
      .exu_mem_wen(exu_mem_wen),
      .exu_mem_waddr(exu_mem_waddr),
      .exu_mem_wdata(exu_mem_wdata),
      .exu_mem_wstrb(exu_mem_wstrb),
      .exu_next_pc(exu_next_pc),
      .rf_wen(rf_wen),
      .rf_waddr(rf_waddr),
      .rf_wdata(rf_wdata),
      .mem_wvalid(mem_wvalid),
      .mem_wready(mem_wready),
      .mem_waddr(mem_waddr),
      .mem_wdata(mem_wdata),
      .mem_wstrb(mem_wstrb),
      .mem_bvalid(mem_bvalid),
      .mem_bresp(mem_bresp),
      .mem_bready(mem_bready),
      .wbu_ifu_valid(wbu_ifu_valid),
      .ifu_wbu_ready(ifu_wbu_ready),
      .wbu_ifu_pc(wbu_ifu_pc),
`ifdef WBU_FWD_EN
      .fwd_valid(fwd_valid),
      .fwd_rd(fwd_rd),
      .fwd_data(fwd_data),
`endif
      .wbu_err(wbu_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic quiet;
      exu_wbu_valid = 1'b0;
      exu_rd_wen    = 1'b0;
      exu_rd        = '0;
      exu_rd_wdata  = '0;
      exu_mem_wen   = 1'b0;
      exu_mem_waddr = '0;
      exu_mem_wdata = '0;
      exu_mem_wstrb = '0;
      exu_next_pc   = '0;
      mem_wready    = 1'b0;
      mem_bvalid    = 1'b0;
      mem_bresp     = 2'b00;
      ifu_wbu_ready = 1'b1;
   endtask

   task automatic send_alu(input logic [4:0] rd, input logic [31:0] d,
                           input logic [31:0] pc);
      exu_wbu_valid = 1'b1;
      exu_rd_wen    = 1'b1;
      exu_rd        = rd;
      exu_rd_wdata  = d;
      exu_mem_wen   = 1'b0;
      exu_next_pc   = pc;
   endtask

   task automatic test_reset;
      quiet();
      rst = 1'b0;
      #12;
      checks++;
      if (wbu_exu_ready !== 1'b0 || mem_wvalid !== 1'b0 ||
          mem_bready !== 1'b0 || wbu_ifu_valid !== 1'b0 ||
          rf_wen !== 1'b0 || wbu_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_outs got rdy=%b wv=%b br=%b iv=%b rw=%b err=%b want 0",
                  wbu_exu_ready, mem_wvalid, mem_bready, wbu_ifu_valid,
                  rf_wen, wbu_err);
      end
      checks++;
      if (rf_waddr !== 5'd0 || rf_wdata !== 32'd0 || wbu_ifu_pc !== 32'd0) begin
         errors++;
         $display("FAIL reset_buf got a=%0d d=%h pc=%h want 0", rf_waddr,
                  rf_wdata, wbu_ifu_pc);
      end
      tick();
      rst = 1'b1;
      #1;
      checks++;
      if (wbu_exu_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready got %b want 1", wbu_exu_ready);
      end
   endtask

   task automatic test_alu;
      tick();
      send_alu(5'd5, 32'hDEADBEEF, 32'h80000004);
      tick();
      quiet();
      checks++;
      if (rf_wen !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEADBEEF ||
          wbu_ifu_valid !== 1'b1 || wbu_ifu_pc !== 32'h80000004) begin
         errors++;
         $display("FAIL alu_commit got wen=%b a=%0d d=%h iv=%b pc=%h want 1 5 deadbeef 1 80000004",
                  rf_wen, rf_waddr, rf_wdata, wbu_ifu_valid, wbu_ifu_pc);
      end
      checks++;
      if (wbu_exu_ready !== 1'b0) begin
         errors++;
         $display("FAIL alu_busy got ready=%b want 0", wbu_exu_ready);
      end
      tick();
      checks++;
      if (wbu_exu_ready !== 1'b1 || rf_wen !== 1'b0 || wbu_ifu_valid !== 1'b0) begin
         errors++;
         $display("FAIL alu_idle got rdy=%b wen=%b iv=%b want 1 0 0",
                  wbu_exu_ready, rf_wen, wbu_ifu_valid);
      end
   endtask

   task automatic test_x0;
      send_alu(5'd0, 32'h11112222, 32'h80000008);
      tick();
      quiet();
      checks++;
      if (wbu_ifu_valid !== 1'b1 || rf_wen !== 1'b0 ||
          wbu_ifu_pc !== 32'h80000008) begin
         errors++;
         $display("FAIL x0_commit got iv=%b wen=%b pc=%h want 1 0 80000008",
                  wbu_ifu_valid, rf_wen, wbu_ifu_pc);
      end
      tick();
      checks++;
      if (rf_wen !== 1'b0 || wbu_exu_ready !== 1'b1) begin
         errors++;
         $display("FAIL x0_after got wen=%b rdy=%b want 0 1", rf_wen, wbu_exu_ready);
      end
   endtask

   task automatic send_store(input logic [1:0] resp);
      exu_wbu_valid = 1'b1;
      exu_rd_wen    = 1'b0;
      exu_rd        = 5'd9;
      exu_mem_wen   = 1'b1;
      exu_mem_waddr = 32'h80001000;
      exu_mem_wdata = 32'h12345678;
      exu_mem_wstrb = 4'hF;
      exu_next_pc   = 32'h8000000C;
      tick();
      // scramble EXU inputs to show the buffer holds
      exu_mem_waddr = 32'hFFFF0000;
      exu_mem_wdata = 32'h0;
      exu_mem_wstrb = 4'h1;
      exu_next_pc   = 32'h0;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (mem_wvalid !== 1'b1 || mem_waddr !== 32'h80001000 ||
             mem_wdata !== 32'h12345678 || mem_wstrb !== 4'hF ||
             wbu_exu_ready !== 1'b0) begin
            errors++;
            $display("FAIL st_req%0d got wv=%b a=%h d=%h s=%h rdy=%b want 1 80001000 12345678 f 0",
                     i, mem_wvalid, mem_waddr, mem_wdata, mem_wstrb, wbu_exu_ready);
         end
         if (i == 3) begin
            mem_wready = 1'b1;
            mem_bvalid = 1'b1;
            mem_bresp  = 2'b11;
         end
         tick();
      end
      exu_wbu_valid = 1'b0;
      mem_wready    = 1'b0;
      mem_bvalid    = 1'b0;
      mem_bresp     = 2'b00;
      checks++;
      if (mem_wvalid !== 1'b0 || mem_bready !== 1'b1 ||
          wbu_ifu_valid !== 1'b0 || wbu_err !== 1'b0) begin
         errors++;
         $display("FAIL st_resp_wait got wv=%b br=%b iv=%b err=%b want 0 1 0 0",
                  mem_wvalid, mem_bready, wbu_ifu_valid, wbu_err);
      end
      tick();
      mem_bvalid = 1'b1;
      mem_bresp  = resp;
      tick();
      mem_bvalid = 1'b0;
      mem_bresp  = 2'b00;
   endtask

   task automatic test_store;
      send_store(2'b00);
      checks++;
      if (wbu_ifu_valid !== 1'b1 || wbu_ifu_pc !== 32'h8000000C ||
          rf_wen !== 1'b0 || wbu_err !== 1'b0 || mem_bready !== 1'b0) begin
         errors++;
         $display("FAIL st_commit got iv=%b pc=%h wen=%b err=%b br=%b want 1 8000000c 0 0 0",
                  wbu_ifu_valid, wbu_ifu_pc, rf_wen, wbu_err, mem_bready);
      end
      tick();
   endtask

   task automatic test_store_err;
      send_store(2'b10);
      checks++;
      if (wbu_ifu_valid !== 1'b1 || wbu_err !== 1'b1) begin
         errors++;
         $display("FAIL sterr_commit got iv=%b err=%b want 1 1", wbu_ifu_valid, wbu_err);
      end
      tick();
      for (int k = 0; k < 10; k++) begin
         send_alu(5'(k + 1), 32'(k), 32'h80000100 + 32'(4 * k));
         tick();
         quiet();
         checks++;
         if (rf_wen !== 1'b1 || rf_waddr !== 5'(k + 1) || wbu_err !== 1'b1) begin
            errors++;
            $display("FAIL sterr_sticky%0d got wen=%b a=%0d err=%b want 1 %0d 1",
                     k, rf_wen, rf_waddr, wbu_err, k + 1);
         end
         tick();
      end
      rst = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (wbu_err !== 1'b0) begin
         errors++;
         $display("FAIL sterr_clear got %b want 0", wbu_err);
      end
   endtask

   task automatic test_backpressure;
      tick();
      send_alu(5'd7, 32'hCAFE0007, 32'h80000200);
      ifu_wbu_ready = 1'b0;
      tick();
      exu_wbu_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (wbu_ifu_valid !== 1'b1 || rf_wen !== 1'b0 || wbu_exu_ready !== 1'b0 ||
             wbu_ifu_pc !== 32'h80000200 || rf_wdata !== 32'hCAFE0007) begin
            errors++;
            $display("FAIL bp_hold%0d got iv=%b wen=%b rdy=%b pc=%h d=%h",
                     i, wbu_ifu_valid, rf_wen, wbu_exu_ready, wbu_ifu_pc, rf_wdata);
         end
         tick();
      end
      ifu_wbu_ready = 1'b1;
      #1;
      checks++;
      if (rf_wen !== 1'b1 || rf_waddr !== 5'd7) begin
         errors++;
         $display("FAIL bp_release got wen=%b a=%0d want 1 7", rf_wen, rf_waddr);
      end
      tick();
      checks++;
      if (rf_wen !== 1'b0 || wbu_ifu_valid !== 1'b0 || wbu_exu_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_after got wen=%b iv=%b rdy=%b want 0 0 1",
                  rf_wen, wbu_ifu_valid, wbu_exu_ready);
      end
   endtask

   task automatic test_mid_reset;
      quiet();
      exu_wbu_valid = 1'b1;
      exu_rd_wen    = 1'b1;
      exu_rd        = 5'd3;
      exu_rd_wdata  = 32'hABCD0003;
      exu_mem_wen   = 1'b1;
      exu_mem_waddr = 32'h80002000;
      exu_next_pc   = 32'h80000300;
      tick();
      quiet();
      checks++;
      if (mem_wvalid !== 1'b1) begin
         errors++;
         $display("FAIL mr_req got wv=%b want 1", mem_wvalid);
      end
`ifdef WBU_FWD_EN
      checks++;
      if (fwd_valid !== 1'b1 || fwd_rd !== 5'd3 || fwd_data !== 32'hABCD0003) begin
         errors++;
         $display("FAIL mr_fwd got v=%b rd=%0d d=%h want 1 3 abcd0003",
                  fwd_valid, fwd_rd, fwd_data);
      end
`endif
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if (mem_wvalid !== 1'b0 || wbu_exu_ready !== 1'b0) begin
         errors++;
         $display("FAIL mr_drop got wv=%b rdy=%b want 0 0", mem_wvalid, wbu_exu_ready);
      end
`ifdef WBU_FWD_EN
      checks++;
      if (fwd_valid !== 1'b0 || fwd_rd !== 5'd0 || fwd_data !== 32'd0) begin
         errors++;
         $display("FAIL mr_fwd_rst got v=%b rd=%0d d=%h want 0", fwd_valid, fwd_rd, fwd_data);
      end
`endif
      tick();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         mem_wready = 1'b1;
         mem_bvalid = 1'b1;
         tick();
         checks++;
         if (wbu_ifu_valid !== 1'b0 || rf_wen !== 1'b0 || mem_wvalid !== 1'b0) begin
            errors++;
            $display("FAIL mr_nocommit%0d got iv=%b wen=%b wv=%b want 0 0 0",
                     i, wbu_ifu_valid, rf_wen, mem_wvalid);
         end
      end
      quiet();
      send_alu(5'd12, 32'h0000F00D, 32'h80000400);
      tick();
      quiet();
      checks++;
      if (rf_wen !== 1'b1 || rf_waddr !== 5'd12 || rf_wdata !== 32'h0000F00D ||
          wbu_ifu_pc !== 32'h80000400) begin
         errors++;
         $display("FAIL mr_next got wen=%b a=%0d d=%h pc=%h want 1 12 0000f00d 80000400",
                  rf_wen, rf_waddr, rf_wdata, wbu_ifu_pc);
      end
      tick();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst    = 1'b1;
      quiet();
      #3;
      test_reset();
      test_alu();
      test_x0();
      test_store();
      test_store_err();
      test_backpressure();
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ysyx_23060187_wbu_gen.md
# ysyx_23060187_wbu_gen

Parametrised write-back unit for the ysyx_23060187 core, between EXU and the register file / data-memory write channel. Each instruction is accepted from EXU over a valid/ready handshake into a one-entry buffer. An optional store is issued over a request/response write channel. The instruction then commits: register-file write plus next-PC handoff to IFU. It is the generalised successor of the single-width, two-state write-back stage, and adds configurable width and register count, a store path with response tracking, error flagging, and an optional forwarding port.

## Interface
- XLEN, 32, data/address width
- NREG, 32, architectural register count (16 for RV32E); RW = $clog2(NREG)
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- exu_wbu_valid  in  1  EXU payload valid
- wbu_exu_ready  out  1  WBU can accept
- exu_rd_wen  in  1  instruction writes rd
- exu_rd  in  RW  destination index
- exu_rd_wdata  in  XLEN  rd data
- exu_mem_wen  in  1  instruction is a store
- exu_mem_waddr  in  XLEN  store address
- exu_mem_wdata  in  XLEN  store data
- exu_mem_wstrb  in  XLEN/8  byte strobes
- exu_next_pc  in  XLEN  next PC
- rf_wen  out  1  register-file write enable
- rf_waddr  out  RW  write index
- rf_wdata  out  XLEN  write data
- mem_wvalid  out  1  store request valid
- mem_wready  in  1  store request accepted
- mem_waddr / mem_wdata / mem_wstrb  out  XLEN / XLEN / XLEN/8  store payload
- mem_bvalid  in  1  store response valid
- mem_bresp  in  2  response code; 0 = OKAY
- mem_bready  out  1  response accept
- wbu_ifu_valid  out  1  commit valid
- ifu_wbu_ready  in  1  IFU accepts commit
- wbu_ifu_pc  out  XLEN  committed next PC
- wbu_err  out  1  sticky store-error flag

## Operation
- FSM states: IDLE, MEM_REQ, MEM_RESP, COMMIT.
- **IDLE**
  - wbu_exu_ready = 1.
  - On exu_wbu_valid, the whole payload latches into the buffer.
  - Next state is MEM_REQ if exu_mem_wen, else COMMIT.
- **MEM_REQ**
  - mem_wvalid = 1, and the payload is driven from the buffer.
  - The payload stays stable until mem_wready; then go to MEM_RESP.
- **MEM_RESP**
  - mem_bready = 1.
  - On mem_bvalid, go to COMMIT. If mem_bresp != 0, set wbu_err; the instruction still commits.
- **COMMIT**
  - wbu_ifu_valid = 1, and wbu_ifu_pc = buffered next PC.
  - On ifu_wbu_ready, rf_wen pulses in that same cycle and the FSM returns to IDLE.
  - rf_wen = buffered rd_wen && (buffered rd != 0); writes to x0 are suppressed.
- wbu_exu_ready is 0 outside IDLE. The buffer is never overwritten before commit.
- rf_waddr/rf_wdata always reflect the buffer. They are qualified only by rf_wen.
- wbu_err is cleared only by reset.

## Timing
- **Reset** (asynchronous, takes effect immediately, also mid-operation):
  - State → IDLE and buffer → 0.
  - All valid/enable outputs (mem_wvalid, mem_bready, wbu_ifu_valid, rf_wen) = 0, and wbu_err = 0.
  - wbu_exu_ready = 1 once reset deasserts.
  - An in-flight store is abandoned; no commit occurs.
- **Non-store latency:** accept in cycle N; wbu_ifu_valid and a possible rf_wen in cycle N+1 if IFU is ready.
- **Store latency:**
  - Accept in cycle N; mem_wvalid from N+1.
  - With mem_wready at N+1 and mem_bvalid at N+2, commit happens at N+3.
- A mem_bvalid arriving in the same cycle as mem_wready is ignored; the response is sampled only in MEM_RESP.
- mem_wready and mem_bvalid are ignored outside their respective states.
- **Throughput:** at most one instruction every 2 cycles, since there is no accept in COMMIT.
- wbu_ifu_valid, once asserted, holds until ifu_wbu_ready. Back-pressure by IFU stalls indefinitely with the outputs stable.

## Configuration
- WBU_FWD_EN
  - **Defined:** adds outputs fwd_valid (1), fwd_rd (RW) and fwd_data (XLEN).
    - fwd_valid = (state != IDLE) && buffered rd_wen && buffered rd != 0, so the buffered result can be forwarded to IDU for hazard resolution.
    - fwd_rd and fwd_data come from the buffer.
    - All three reset to 0.
  - **Undefined:** the ports and their logic are absent; behaviour is otherwise identical.

## Test plan
- **ALU write, no store:** exu_rd=5, data 0xDEADBEEF, next_pc 0x80000004, IFU ready.
  - Required: one cycle after accept, rf_wen=1, waddr=5, wdata=0xDEADBEEF, wbu_ifu_pc=0x80000004.
  - Required: wbu_exu_ready high again the following cycle.
- **x0 write:** exu_rd=0, rd_wen=1 → commit occurs with rf_wen never 1.
- **Store:** addr 0x80001000, data 0x12345678, wstrb 0xF; mem_wready delayed 3 cycles, bvalid 2 cycles later, bresp=0.
  - Required: mem_wvalid held 4 cycles with a stable payload.
  - Required: commit follows the cycle after bvalid, and wbu_err=0.
- **Store error:** bresp=2 → wbu_err=1 after the response; the commit still occurs; wbu_err stays 1 across 10 further instructions until rst pulses.
- **IFU back-pressure:** ifu_wbu_ready low for 5 cycles in COMMIT.
  - Required: wbu_ifu_valid held, rf_wen=0 and wbu_exu_ready=0 throughout.
  - Required: a single rf_wen pulse on the release cycle.
- **Mid-operation reset:** rst low while in MEM_REQ.
  - Required: mem_wvalid drops combinationally.
  - Required after release: no commit; the next accepted instruction completes normally.
  - With WBU_FWD_EN: fwd_valid = 1 during the store wait, and 0 after reset.
